// File: rtl/tlc_timer.sv
// Traffic-light interval timer: one saturating up-counter decoded into TS/TL, plus a conditioned car sensor.
// Optional build macro CAR_DEBOUNCE_EN adds a DB_CYCLES stability filter on the synchronized car input.
module tlc_timer #(
  parameter int CNT_W     = 8,
  parameter int TS_CYCLES = 4,
  parameter int TL_CYCLES = 16,
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ST,
  input  logic CAR_RAW,
  output logic TS,
  output logic TL,
  output logic C,
  output logic BUSY
);

  if (TS_CYCLES < 1 || TS_CYCLES >= TL_CYCLES || DB_CYCLES < 1 ||
      longint'(TL_CYCLES) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_param_err
    $error("tlc_timer: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] TS_VAL = CNT_W'(TS_CYCLES);
  localparam logic [CNT_W-1:0] TL_VAL = CNT_W'(TL_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             car_q1;
  logic             car_s;

  // Reset release behaves like an ST sample: counting begins from 0 on the first edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ST) begin
      cnt <= '0;
    end else if (cnt < TL_VAL) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TS   = (cnt >= TS_VAL);
  assign TL   = (cnt == TL_VAL);
  assign BUSY = ~TL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      car_q1 <= 1'b0;
      car_s  <= 1'b0;
    end else begin
      car_q1 <= CAR_RAW;
      car_s  <= car_q1;
    end
  end

`ifdef CAR_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            car_c;

  // Down-counter runs only while car_s disagrees with C; terminal count commits the new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= DB_RELOAD;
      car_c  <= 1'b0;
    end else if (car_s == car_c) begin
      db_cnt <= DB_RELOAD;
    end else if (db_cnt == '0) begin
      car_c  <= car_s;
      db_cnt <= DB_RELOAD;
    end else begin
      db_cnt <= db_cnt - 1'b1;
    end
  end

  assign C = car_c;
`else
  assign C = car_s;
`endif

endmodule

// File: tb/tb_tlc_timer.sv
// Directed bench for tlc_timer with default parameters; a small reference model supplies expected outputs.
module tb_tlc_timer;

  localparam int TS_N = 4;
  localparam int TL_N = 16;
  localparam int DB_N = 3;

  logic clk;
  logic reset;
  logic ST;
  logic CAR_RAW;
  logic TS, TL, C, BUSY;

  int checks = 0;
  int errors = 0;

  int   m_cnt;
  logic m_q1, m_s, m_c;
  int   m_run;

  tlc_timer #(.CNT_W(8), .TS_CYCLES(TS_N), .TL_CYCLES(TL_N), .DB_CYCLES(DB_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .ST     (ST),
    .CAR_RAW(CAR_RAW),
    .TS     (TS),
    .TL     (TL),
    .C      (C),
    .BUSY   (BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_q1  = 1'b0;
    m_s   = 1'b0;
    m_c   = 1'b0;
    m_run = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_ts"},   {31'd0, TS},   {31'd0, (m_cnt >= TS_N)});
    check_val({tag, "_tl"},   {31'd0, TL},   {31'd0, (m_cnt == TL_N)});
    check_val({tag, "_busy"}, {31'd0, BUSY}, {31'd0, (m_cnt != TL_N)});
    check_val({tag, "_c"},    {31'd0, C},    {31'd0, m_c});
  endtask

  // One clock edge with ST applied, then model update and output checks 1 time unit later.
  task automatic step(input logic st_v, input string tag);
    ST = st_v;
    @(posedge clk);
    #1;
    if (st_v) m_cnt = 0;
    else if (m_cnt < TL_N) m_cnt = m_cnt + 1;
`ifdef CAR_DEBOUNCE_EN
    if (m_s != m_c) begin
      m_run = m_run + 1;
      if (m_run == DB_N) begin
        m_c   = m_s;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s  = m_q1;
    m_q1 = CAR_RAW;
`else
    m_s  = m_q1;
    m_q1 = CAR_RAW;
    m_c  = m_s;
`endif
    check_outputs(tag);
  endtask

  // Called just after an edge: pulses reset between edges and checks the asynchronous clear.
  task automatic pulse_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    check_val({tag, "_ts"},   {31'd0, TS},   32'd0);
    check_val({tag, "_tl"},   {31'd0, TL},   32'd0);
    check_val({tag, "_c"},    {31'd0, C},    32'd0);
    check_val({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    ST      = 1'b0;
    CAR_RAW = 1'b0;
    model_reset();

    #2;
    check_val("rst_ts",   {31'd0, TS},   32'd0);
    check_val("rst_tl",   {31'd0, TL},   32'd0);
    check_val("rst_busy", {31'd0, BUSY}, 32'd1);
    check_val("rst_c",    {31'd0, C},    32'd0);
    CAR_RAW = 1'b1;
    #20;
    check_val("rst_hold_c",  {31'd0, C},  32'd0);
    check_val("rst_hold_ts", {31'd0, TS}, 32'd0);
    CAR_RAW = 1'b0;
    #1;
    reset = 1'b1;

    // Free run from release: TS after edge 4, TL after edge 16, then saturate.
    for (int i = 1; i <= 36; i++) begin
      step(1'b0, "run");
      if (i == 3)  check_val("run_ts_e3",  {31'd0, TS}, 32'd0);
      if (i == 4)  check_val("run_ts_e4",  {31'd0, TS}, 32'd1);
      if (i == 15) check_val("run_tl_e15", {31'd0, TL}, 32'd0);
      if (i == 16) check_val("run_tl_e16", {31'd0, TL}, 32'd1);
    end

    // ST pulse at edge 10 after release.
    pulse_reset("rst_a");
    for (int i = 1; i <= 9; i++) step(1'b0, "pre_st");
    step(1'b1, "st10");
    check_val("st10_ts", {31'd0, TS}, 32'd0);
    for (int i = 11; i <= 30; i++) begin
      step(1'b0, "post_st");
      if (i == 13) check_val("post_ts_e13", {31'd0, TS}, 32'd0);
      if (i == 14) check_val("post_ts_e14", {31'd0, TS}, 32'd1);
      if (i == 25) check_val("post_tl_e25", {31'd0, TL}, 32'd0);
      if (i == 26) check_val("post_tl_e26", {31'd0, TL}, 32'd1);
    end

    // ST held for 5 edges while TL is high.
    for (int i = 0; i < 5; i++) step(1'b1, "st_hold");
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, "st_rel");
      if (i == 3) check_val("st_rel_ts3", {31'd0, TS}, 32'd0);
      if (i == 4) check_val("st_rel_ts4", {31'd0, TS}, 32'd1);
    end

    // Asynchronous reset at cnt=7 with the car flag set.
    pulse_reset("rst_b");
    CAR_RAW = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b0, "to7");
    check_val("to7_c", {31'd0, C}, 32'd1);
    pulse_reset("rst_mid");
    CAR_RAW = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, "restart");

    // Car sensor: a short pulse, then a long one.
    CAR_RAW = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, "car_short");
    CAR_RAW = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, "car_gap");
    CAR_RAW = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, "car_long");
`ifdef CAR_DEBOUNCE_EN
      if (i == 4) check_val("car_long_e4", {31'd0, C}, 32'd0);
      if (i == 5) check_val("car_long_e5", {31'd0, C}, 32'd1);
`else
      if (i == 1) check_val("car_long_e1", {31'd0, C}, 32'd0);
      if (i == 2) check_val("car_long_e2", {31'd0, C}, 32'd1);
`endif
    end
    CAR_RAW = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, "car_fall");
    check_val("car_final", {31'd0, C}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
